// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for imm_gen_pipe: an instruction/ext_sel request side and
// an immediate/type_err response side, plus the synchronous flush strobe.
interface imm_gen_pipe_if #(
  parameter int XLEN      = 32,
  parameter int ERR_CNT_W = 8
);
  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          instr;
  logic [3:0]           ext_sel;
  logic                 out_valid;
  logic                 out_ready;
  logic [XLEN-1:0]      imm;
  logic                 type_err;
  logic [ERR_CNT_W-1:0] err_cnt;

  // Producer/consumer side (decode stage, testbench)
  modport master (
    output flush, in_valid, instr, ext_sel, out_ready,
    input  in_ready, out_valid, imm, type_err, err_cnt
  );

  // Immediate generator side
  modport slave (
    input  flush, in_valid, instr, ext_sel, out_ready,
    output in_ready, out_valid, imm, type_err, err_cnt
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Immediate generator with a registered valid/ready output stage.
// Words are decoded as they are accepted and held in a main register (M) with a
// skid register (K) behind it, so in_ready is purely registered and never
// depends combinationally on out_ready.
module imm_gen_pipe #(
  parameter int XLEN      = 32,
  parameter int SIGN_EXT  = 1,
  parameter int ERR_CNT_W = 8
) (
  input  logic          clock,
  input  logic          reset,
  imm_gen_pipe_if.slave bus
);

  typedef struct packed {
    logic            type_err;
    logic [XLEN-1:0] imm;
  } word_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  // Decode into a 64-bit scratch value and truncate, so the same code serves
  // XLEN=32 and XLEN=64 without zero-width replications.
  function automatic word_t decode(input logic [31:0] i, input logic [3:0] sel);
    logic [63:0] w;
    logic        e;
    word_t       r;
    e          = (SIGN_EXT != 0) ? i[31] : 1'b0;
    w          = '0;
    r.type_err = 1'b0;
    case (sel[2:0])
      3'd0: w = '0;
      3'd1: w = {{52{e}}, i[31:20]};
      3'd2: w = {{52{e}}, i[31:25], i[11:7]};
      3'd3: w = {{51{e}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'd4: w = sel[3] ? {{52{e}}, i[31:20]}
                       : {{43{e}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      3'd5: w = {{32{e}}, i[31:12], 12'b0};
      default: r.type_err = 1'b1;
    endcase
    r.imm = w[XLEN-1:0];
    return r;
  endfunction

  state_t               state;
  word_t                m_q, k_q, new_w;
  logic                 in_ready_q, out_valid_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;
  logic                 acc, pop;

  assign new_w = decode(bus.instr, bus.ext_sel);
  assign acc   = bus.in_valid & in_ready_q;
  assign pop   = out_valid_q & bus.out_ready;

  // Buffer FSM, registered handshake outputs and saturating illegal-type counter
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= EMPTY;
      m_q         <= '0;
      k_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      // Counting happens even when the same cycle flushes the word away
      if (acc && new_w.type_err && !(&err_cnt_q))
        err_cnt_q <= err_cnt_q + 1'b1;

      if (bus.flush) begin
        state       <= EMPTY;
        in_ready_q  <= 1'b1;
        out_valid_q <= 1'b0;
      end else begin
        case (state)
          EMPTY: begin
            if (acc) begin
              m_q         <= new_w;
              state       <= ONE;
              out_valid_q <= 1'b1;
            end
          end
          ONE: begin
            if (acc && !pop) begin
              k_q        <= new_w;
              state      <= FULL;
              in_ready_q <= 1'b0;
            end else if (acc && pop) begin
              m_q <= new_w;
            end else if (pop) begin
              state       <= EMPTY;
              out_valid_q <= 1'b0;
            end
          end
          FULL: begin
            // in_ready is low here, so only a pop can move the state
            if (pop) begin
              m_q        <= k_q;
              state      <= ONE;
              in_ready_q <= 1'b1;
            end
          end
          default: begin
            state       <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.imm       = m_q.imm;
  assign bus.type_err  = m_q.type_err;
  assign bus.err_cnt   = err_cnt_q;

endmodule
